// File: rtl/cmp_result_stats.sv
// cmp_result_stats: per-frame statistics over a stream of compare codes.
// Counts gt/lt/eq/illegal codes and the longest eq run, then reports.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, code[N], in_last : code stream in
//   stat_valid/stat_ready               : summary handshake out
//   gt_cnt, lt_cnt, eq_cnt, eq_run_max, err_cnt [CNT_W] : summary
// Define CMP_STATS_ILLEGAL_EN to count illegal codes in err_cnt.
// Otherwise err_cnt is 0 and illegal beats are dropped.
module cmp_result_stats #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     code,
  input  logic             in_last,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] eq_run_max,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [N-1:0]     C_GT = N'(1);
  localparam logic [N-1:0]     C_LT = '1;
  localparam logic [N-1:0]     C_EQ = '0;

  state_t state_q, state_d;

  logic [CNT_W-1:0] gt_q, lt_q, eq_q;
  logic [CNT_W-1:0] run_q, max_q, run_inc;
  logic             acc, done;
  logic             is_gt, is_lt, is_eq;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == MAXV) ? v : v + CNT_W'(1);
  endfunction

  assign acc = in_valid && in_ready;
  assign done = stat_valid && stat_ready;

  // For N=1, gt and lt share an encoding; gt wins.
  assign is_gt = (code == C_GT);
  assign is_lt = (code == C_LT) && !is_gt;
  assign is_eq = (code == C_EQ);

  assign run_inc = sat_inc(run_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    stat_valid = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last)
          state_d = REPORT;
      end
      REPORT: begin
        stat_valid = 1'b1;
        if (stat_ready)
          state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

`ifdef CMP_STATS_ILLEGAL_EN
  logic [CNT_W-1:0] err_q;
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst || done) begin
      gt_q  <= '0;
      lt_q  <= '0;
      eq_q  <= '0;
      run_q <= '0;
      max_q <= '0;
`ifdef CMP_STATS_ILLEGAL_EN
      err_q <= '0;
`endif
    end else if (acc) begin
      unique case (1'b1)
        is_gt: begin
          gt_q  <= sat_inc(gt_q);
          run_q <= '0;
        end
        is_lt: begin
          lt_q  <= sat_inc(lt_q);
          run_q <= '0;
        end
        is_eq: begin
          eq_q  <= sat_inc(eq_q);
          run_q <= run_inc;
          if (run_inc > max_q)
            max_q <= run_inc;
        end
        default: begin
`ifdef CMP_STATS_ILLEGAL_EN
          err_q <= sat_inc(err_q);
          run_q <= '0;
`endif
        end
      endcase
    end
  end

  assign gt_cnt     = gt_q;
  assign lt_cnt     = lt_q;
  assign eq_cnt     = eq_q;
  assign eq_run_max = max_q;

endmodule

// File: tb/tb_cmp_result_stats.sv
// tb_cmp_result_stats: directed scoreboard bench for cmp_result_stats.
// Expected summaries are queued per frame and popped at stat_valid.
module tb_cmp_result_stats;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] code;
  logic         in_last;
  logic         stat_valid;
  logic         stat_ready;
  logic [W-1:0] gt_cnt, lt_cnt, eq_cnt;
  logic [W-1:0] eq_run_max, err_cnt;

  cmp_result_stats #(.N(N), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code       (code),
    .in_last    (in_last),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .gt_cnt     (gt_cnt),
    .lt_cnt     (lt_cnt),
    .eq_cnt     (eq_cnt),
    .eq_run_max (eq_run_max),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] gt;
    logic [W-1:0] lt;
    logic [W-1:0] eq;
    logic [W-1:0] run;
    logic [W-1:0] err;
  } sum_t;

  int     vecs = 0;
  int     errs = 0;
  sum_t   sb[$];
  sum_t   m;
  sum_t   s;
  logic [W-1:0] cur;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sat(input logic [W-1:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    m   = '0;
    cur = '0;
  endtask

  task automatic model_beat(input logic [N-1:0] c,
                            input logic last);
    if (c == 4'b0001) begin
      m.gt = sat(m.gt); cur = '0;
    end else if (c == 4'b1111) begin
      m.lt = sat(m.lt); cur = '0;
    end else if (c == 4'b0000) begin
      m.eq = sat(m.eq);
      cur  = sat(cur);
      if (cur > m.run) m.run = cur;
    end else begin
`ifdef CMP_STATS_ILLEGAL_EN
      m.err = sat(m.err);
      cur   = '0;
`endif
    end
    if (last) begin
      sb.push_back(m);
      model_reset();
    end
  endtask

  task automatic beat(input logic [N-1:0] c, input logic last);
    @(negedge clk);
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    code     = c;
    in_last  = last;
    model_beat(c, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called 1 time unit after the edge that accepted in_last.
  task automatic expect_summary(input string tag);
    chk({tag, "_valid"}, 32'(stat_valid), 32'd1);
    chk({tag, "_ready0"}, 32'(in_ready), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      s = '0;
    end else begin
      s = sb.pop_front();
      chk({tag, "_gt"}, 32'(gt_cnt), 32'(s.gt));
      chk({tag, "_lt"}, 32'(lt_cnt), 32'(s.lt));
      chk({tag, "_eq"}, 32'(eq_cnt), 32'(s.eq));
      chk({tag, "_run"}, 32'(eq_run_max), 32'(s.run));
      chk({tag, "_err"}, 32'(err_cnt), 32'(s.err));
    end
  endtask

  task automatic release_summary(input string tag);
    @(negedge clk);
    stat_ready = 1'b1;
    @(posedge clk);
    #1;
    stat_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(stat_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_rel_zero"},
        32'(gt_cnt | lt_cnt | eq_cnt | eq_run_max | err_cnt),
        32'd0);
  endtask

  logic [N-1:0] rc;
  logic [N-1:0] pick [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; code = '0;
    in_last = 1'b0; stat_ready = 1'b0;
    model_reset();
    pick[0] = 4'b0000; pick[1] = 4'b0001;
    pick[2] = 4'b1111; pick[3] = 4'b0110;

    // reset state
    @(posedge clk); #1;
    chk("rst_valid", 32'(stat_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(stat_valid), 32'd0);
    chk("post_rst_zero",
        32'(gt_cnt | lt_cnt | eq_cnt | eq_run_max | err_cnt),
        32'd0);

    // basic frame
    beat(4'b0001, 0); beat(4'b0000, 0); beat(4'b0000, 0);
    beat(4'b1111, 0); beat(4'b0000, 1);
    expect_summary("basic");
    chk("basic_gt_c", 32'(gt_cnt), 32'd1);
    chk("basic_lt_c", 32'(lt_cnt), 32'd1);
    chk("basic_eq_c", 32'(eq_cnt), 32'd3);
    chk("basic_run_c", 32'(eq_run_max), 32'd2);
    release_summary("basic");

    // hold summary with stat_ready low, upstream still pushing
    beat(4'b0000, 0); beat(4'b0000, 0); beat(4'b0001, 1);
    expect_summary("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; code = 4'b0000; in_last = 1'b1;
      @(posedge clk); #1;
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(stat_valid), 32'd1);
      chk("hold_eq", 32'(eq_cnt), 32'(s.eq));
      chk("hold_run", 32'(eq_run_max), 32'(s.run));
      chk("hold_gt", 32'(gt_cnt), 32'(s.gt));
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_summary("hold");

    // saturation
    for (int i = 0; i < 300; i++)
      beat(4'b0000, i == 299);
    expect_summary("sat");
    chk("sat_eq_c", 32'(eq_cnt), 32'd255);
    chk("sat_run_c", 32'(eq_run_max), 32'd255);
    release_summary("sat");

    // illegal code in the middle of an eq run
    beat(4'b0000, 0); beat(4'b0000, 0);
    beat(4'b0101, 0); beat(4'b0000, 1);
    expect_summary("illegal");
`ifdef CMP_STATS_ILLEGAL_EN
    chk("illegal_err_c", 32'(err_cnt), 32'd1);
    chk("illegal_run_c", 32'(eq_run_max), 32'd2);
`else
    chk("illegal_err_c", 32'(err_cnt), 32'd0);
    chk("illegal_run_c", 32'(eq_run_max), 32'd3);
`endif
    release_summary("illegal");

    // illegal code carrying in_last still ends the frame
    beat(4'b1010, 1);
    expect_summary("ill_last");
    release_summary("ill_last");

    // reset mid-frame
    beat(4'b0001, 0); beat(4'b0000, 0); beat(4'b1111, 0);
    @(negedge clk); rst = 1'b1;
    in_valid = 1'b1; code = 4'b0001; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_reset();
    chk("midrst_valid", 32'(stat_valid), 32'd0);
    chk("midrst_zero",
        32'(gt_cnt | lt_cnt | eq_cnt | eq_run_max),
        32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid2", 32'(stat_valid), 32'd0);
    beat(4'b0001, 1);
    expect_summary("after_rst");
    chk("after_rst_gt_c", 32'(gt_cnt), 32'd1);
    release_summary("after_rst");

    // reset while a summary is pending
    beat(4'b0000, 1);
    expect_summary("rep_rst");
    @(negedge clk); rst = 1'b1; stat_ready = 1'b1;
    @(posedge clk); #1;
    stat_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rep_rst_valid", 32'(stat_valid), 32'd0);
    chk("rep_rst_ready", 32'(in_ready), 32'd1);
    chk("rep_rst_eq", 32'(eq_cnt), 32'd0);

    // single-beat lt frame
    beat(4'b1111, 1);
    expect_summary("single");
    chk("single_lt_c", 32'(lt_cnt), 32'd1);
    chk("single_run_c", 32'(eq_run_max), 32'd0);
    release_summary("single");

    // a few pseudo-random frames
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 12; i++) begin
        rc = pick[$urandom_range(0, 3)];
        beat(rc, i == 11);
      end
      expect_summary("rand");
      release_summary("rand");
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
